pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter MEM_STALL, default 1, legal 1..4: load-use bubbles inserted per load-use hazard.
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 rs_id, rt_id  in  REG_AW each  source registers of the instruction held in IF/ID.
REQ-007 rs_ex, rt_ex  in  REG_AW each  source registers of the instruction held in ID/EX.
REQ-008 ex_mem_read  in  1  ID/EX instruction is a load; ex_rw  in  REG_AW  its destination.
REQ-009 rw_mem  in  REG_AW, reg_write_mem  in  1  EX/MEM destination and write enable.
REQ-010 rw_wb  in  REG_AW, reg_write_wb  in  1  MEM/WB destination and write enable.
REQ-011 branch_taken  in  1  branch resolved taken in ID this cycle.
REQ-012 mc_start  in  1  multi-cycle op (mul/div) entered EX; mc_done  in  1  op result ready.
REQ-013 pc_write, if_id_write  out  1 each  PC and IF/ID update enables.
REQ-014 bubble_sel  out  1  zero ID/EX control signals; if_id_flush  out  1  squash IF/ID.
REQ-015 fwd_a, fwd_b  out  2 each  ALU operand source: 00 register file, 01 WB bus, 10 EX/MEM ALU result.
REQ-016 stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-017 fwd_a SHALL be 10 when reg_write_mem, rw_mem!=0 and rw_mem==rs_ex; else 01 when reg_write_wb, rw_wb!=0 and rw_wb==rs_ex; else 00 (combinational; EX/MEM wins over MEM/WB).
REQ-018 fwd_b SHALL follow REQ-017 with rt_ex replacing rs_ex.
REQ-019 Load-use hazard SHALL be ex_mem_read and ex_rw!=0 and (ex_rw==rs_id or ex_rw==rt_id).
REQ-020 FSM states SHALL be RUN, LOAD_STALL, MC_WAIT.
REQ-021 RUN priority SHALL be branch_taken > mc_start > load-use.
REQ-022 RUN + branch_taken: if_id_flush=1, no stall, load-use suppressed, stay RUN.
REQ-023 RUN + mc_start: no stall that cycle; next state MC_WAIT.
REQ-024 RUN + load-use: pc_write=0, if_id_write=0, bubble_sel=1 that cycle; if MEM_STALL>1 load remaining-count with MEM_STALL-1 and enter LOAD_STALL, else stay RUN.
REQ-025 LOAD_STALL: stall outputs as REQ-024 each cycle, decrement count, return to RUN after count reaches 0; total stall exactly MEM_STALL cycles.
REQ-026 MC_WAIT: stall outputs asserted while mc_done=0; cycle mc_done=1 releases stall in that same cycle and next state RUN.
REQ-027 mc_done in RUN/LOAD_STALL, mc_start outside RUN, and branch_taken while any stall output asserted SHALL be ignored.
REQ-028 Idle (RUN, no event): pc_write=1, if_id_write=1, bubble_sel=0, if_id_flush=0.
REQ-029 stall_cycles SHALL increment by 1 on every cycle pc_write=0 and hold at 2^CNT_W-1.

Reset
REQ-030 reset=0 at an edge SHALL force state RUN, remaining-count 0, stall_cycles 0, including mid-stall or mid-MC_WAIT.
REQ-031 While reset=0, outputs SHALL be pc_write=1, if_id_write=1, bubble_sel=0, if_id_flush=0, fwd_a=fwd_b=00.

Structure
REQ-032 Shared package pipeline_pkg SHALL hold the FSM state type and constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
REQ-033 One sub-module fwd_src_select SHALL implement REQ-017, instantiated twice (A, B).

Verification
REQ-034 rs_ex=3, rw_mem=3, reg_write_mem=1, rw_wb=3, reg_write_wb=1 -> fwd_a=10; drop reg_write_mem -> 01; rs_ex=0 -> 00.
REQ-035 MEM_STALL=3, ex_mem_read=1, ex_rw=7, rt_id=7 -> pc_write=0, bubble_sel=1 for exactly 3 cycles, stall_cycles=3.
REQ-036 Same hazard with branch_taken=1 -> if_id_flush=1 one cycle, no stall, stall_cycles unchanged.
REQ-037 mc_start pulse, mc_done high 5 cycles later -> 4 stall cycles, release on mc_done cycle, state RUN next.
REQ-038 reset=0 during MC_WAIT cycle 2 -> next cycle RUN, pc_write=1, stall_cycles=0; CNT_W=4 with 20 stalls -> stall_cycles=15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_t  : hazard-control FSM state (RUN, LOAD_STALL, MC_WAIT)
//   FWD_*    : ALU operand source encodings driven on fwd_a / fwd_b
//   REM_W    : width of the load-use remaining-bubble counter
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MC_WAIT    = 2'd2
    } state_t;

    // Operand source select: register file, WB bus, EX/MEM ALU result.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MEM_STALL is at most 4, so at most 3 bubbles remain after the first.
    localparam int REM_W = 2;

endpackage : pipeline_pkg

// File: rtl/fwd_src_select.sv
// -----------------------------------------------------------------------------
// fwd_src_select
// Chooses the forwarding source for one ALU operand.
// Ports:
//   src_reg        in  REG_AW  source register of the instruction in ID/EX
//   rw_mem         in  REG_AW  EX/MEM destination register
//   reg_write_mem  in  1       EX/MEM writes the register file
//   rw_wb          in  REG_AW  MEM/WB destination register
//   reg_write_wb   in  1       MEM/WB writes the register file
//   fwd_sel        out 2       FWD_MEM / FWD_WB / FWD_RF
// The younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
// -----------------------------------------------------------------------------
module fwd_src_select
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_reg,
    input  logic [REG_AW-1:0] rw_mem,
    input  logic              reg_write_mem,
    input  logic [REG_AW-1:0] rw_wb,
    input  logic              reg_write_wb,
    output logic [1:0]        fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_mem && (rw_mem != '0) && (rw_mem == src_reg)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_wb && (rw_wb != '0) && (rw_wb == src_reg)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule : fwd_src_select

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard detection, stall/flush control and operand forwarding for a 5-stage
// pipeline.
// Parameters:
//   REG_AW     register-address width
//   MEM_STALL  bubbles inserted per load-use hazard (1..4)
//   CNT_W      width of the saturating stall counter
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-low reset
//   rs_id, rt_id                  IF/ID source registers
//   rs_ex, rt_ex                  ID/EX source registers
//   ex_mem_read, ex_rw            ID/EX is a load, and its destination
//   rw_mem, reg_write_mem         EX/MEM destination / write enable
//   rw_wb, reg_write_wb           MEM/WB destination / write enable
//   branch_taken                  branch resolved taken in ID
//   mc_start, mc_done             multi-cycle op entered EX / result ready
//   pc_write, if_id_write         PC and IF/ID update enables
//   bubble_sel, if_id_flush       zero ID/EX controls / squash IF/ID
//   fwd_a, fwd_b                  ALU operand source selects
//   stall_cycles                  saturating count of cycles with pc_write=0
//   state_dbg                     current FSM state
// There are no valid/ready handshakes here: every input is a level that is
// evaluated each cycle, and every output is a per-cycle level.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int MEM_STALL = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rw,
    input  logic [REG_AW-1:0] rw_mem,
    input  logic              reg_write_mem,
    input  logic [REG_AW-1:0] rw_wb,
    input  logic              reg_write_wb,
    input  logic              branch_taken,
    input  logic              mc_start,
    input  logic              mc_done,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              bubble_sel,
    output logic              if_id_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cycles,
    output state_t            state_dbg
);

    // Bubbles still owed after the first one, which is issued from RUN.
    localparam logic [REM_W-1:0] STALL_RELOAD = REM_W'(MEM_STALL - 1);

    state_t           state, state_nxt;
    logic [REM_W-1:0] rem_cnt, rem_nxt;
    logic             load_use;
    logic             stall_raw;
    logic             flush_raw;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;

    // ---------------------------------------------------------------------
    // Forwarding
    // ---------------------------------------------------------------------
    fwd_src_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src_reg       (rs_ex),
        .rw_mem        (rw_mem),
        .reg_write_mem (reg_write_mem),
        .rw_wb         (rw_wb),
        .reg_write_wb  (reg_write_wb),
        .fwd_sel       (fwd_a_raw)
    );

    fwd_src_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src_reg       (rt_ex),
        .rw_mem        (rw_mem),
        .reg_write_mem (reg_write_mem),
        .rw_wb         (rw_wb),
        .reg_write_wb  (reg_write_wb),
        .fwd_sel       (fwd_b_raw)
    );

    // ---------------------------------------------------------------------
    // Load-use detection: the load in ID/EX feeds the instruction in IF/ID.
    // ---------------------------------------------------------------------
    assign load_use = ex_mem_read && (ex_rw != '0) &&
                      ((ex_rw == rs_id) || (ex_rw == rt_id));

    // ---------------------------------------------------------------------
    // FSM next-state and raw control outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem_cnt;
        stall_raw = 1'b0;
        flush_raw = 1'b0;
        case (state)
            RUN: begin
                // A taken branch squashes IF/ID, so a load-use hazard against
                // that squashed instruction does not matter.
                if (branch_taken) begin
                    flush_raw = 1'b1;
                end else if (mc_start) begin
                    state_nxt = MC_WAIT;
                end else if (load_use) begin
                    stall_raw = 1'b1;
                    if (MEM_STALL > 1) begin
                        rem_nxt   = STALL_RELOAD;
                        state_nxt = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                stall_raw = 1'b1;
                if (rem_cnt <= REM_W'(1)) begin
                    rem_nxt   = '0;
                    state_nxt = RUN;
                end else begin
                    rem_nxt = rem_cnt - REM_W'(1);
                end
            end
            MC_WAIT: begin
                // mc_done releases the stall in the same cycle; once released
                // a taken branch may flush again.
                if (mc_done) begin
                    state_nxt = RUN;
                    flush_raw = branch_taken;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
                rem_nxt   = '0;
            end
        endcase
    end

    // Outputs are forced to the free-running idle values while in reset.
    assign pc_write    = !(reset && stall_raw);
    assign if_id_write = !(reset && stall_raw);
    assign bubble_sel  = reset && stall_raw;
    assign if_id_flush = reset && flush_raw;
    assign fwd_a       = reset ? fwd_a_raw : FWD_RF;
    assign fwd_b       = reset ? fwd_b_raw : FWD_RF;
    assign state_dbg   = state;

    // ---------------------------------------------------------------------
    // State, bubble counter and saturating stall counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= RUN;
            rem_cnt      <= '0;
            stall_cycles <= '0;
        end else begin
            state   <= state_nxt;
            rem_cnt <= rem_nxt;
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Two instances share all inputs:
// dut (MEM_STALL=3, CNT_W=16) and dut_s (MEM_STALL=3, CNT_W=4, used for the
// counter saturation case). Inputs change just after a falling edge, outputs
// are sampled 1 time unit later, state advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    import pipeline_pkg::*;

    localparam int REG_AW = 5;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clock;
    logic reset;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------------------------------------------------------------
    // DUT signals
    // ---------------------------------------------------------------------
    logic [REG_AW-1:0] rs_id, rt_id, rs_ex, rt_ex, ex_rw, rw_mem, rw_wb;
    logic              ex_mem_read, reg_write_mem, reg_write_wb;
    logic              branch_taken, mc_start, mc_done;

    logic        pc_write, if_id_write, bubble_sel, if_id_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles;
    state_t      state_dbg;

    logic        pc_write_s, if_id_write_s, bubble_sel_s, if_id_flush_s;
    logic [1:0]  fwd_a_s, fwd_b_s;
    logic [3:0]  stall_cycles_s;
    state_t      state_dbg_s;

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MEM_STALL(3), .CNT_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .rs_id         (rs_id),
        .rt_id         (rt_id),
        .rs_ex         (rs_ex),
        .rt_ex         (rt_ex),
        .ex_mem_read   (ex_mem_read),
        .ex_rw         (ex_rw),
        .rw_mem        (rw_mem),
        .reg_write_mem (reg_write_mem),
        .rw_wb         (rw_wb),
        .reg_write_wb  (reg_write_wb),
        .branch_taken  (branch_taken),
        .mc_start      (mc_start),
        .mc_done       (mc_done),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .bubble_sel    (bubble_sel),
        .if_id_flush   (if_id_flush),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_cycles  (stall_cycles),
        .state_dbg     (state_dbg)
    );

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MEM_STALL(3), .CNT_W(4)) dut_s (
        .clock         (clock),
        .reset         (reset),
        .rs_id         (rs_id),
        .rt_id         (rt_id),
        .rs_ex         (rs_ex),
        .rt_ex         (rt_ex),
        .ex_mem_read   (ex_mem_read),
        .ex_rw         (ex_rw),
        .rw_mem        (rw_mem),
        .reg_write_mem (reg_write_mem),
        .rw_wb         (rw_wb),
        .reg_write_wb  (reg_write_wb),
        .branch_taken  (branch_taken),
        .mc_start      (mc_start),
        .mc_done       (mc_done),
        .pc_write      (pc_write_s),
        .if_id_write   (if_id_write_s),
        .bubble_sel    (bubble_sel_s),
        .if_id_flush   (if_id_flush_s),
        .fwd_a         (fwd_a_s),
        .fwd_b         (fwd_b_s),
        .stall_cycles  (stall_cycles_s),
        .state_dbg     (state_dbg_s)
    );

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Driver helpers
    // ---------------------------------------------------------------------
    task automatic clear_inputs();
        rs_id         = '0;
        rt_id         = '0;
        rs_ex         = '0;
        rt_ex         = '0;
        ex_rw         = '0;
        rw_mem        = '0;
        rw_wb         = '0;
        ex_mem_read   = 1'b0;
        reg_write_mem = 1'b0;
        reg_write_wb  = 1'b0;
        branch_taken  = 1'b0;
        mc_start      = 1'b0;
        mc_done       = 1'b0;
    endtask

    // Watchdog: the directed sequence is only a few hundred cycles long.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        clear_inputs();
        reset = 1'b0;

        // Reset held with a forwarding match, a load-use hazard and a branch
        // all present: outputs must still be the idle values.
        rs_ex = 5'd3; rt_ex = 5'd3; rw_mem = 5'd3; reg_write_mem = 1'b1;
        ex_mem_read = 1'b1; ex_rw = 5'd7; rt_id = 5'd7; branch_taken = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        chk("rst_pc_write",    32'(pc_write),     32'd1);
        chk("rst_if_id_write", 32'(if_id_write),  32'd1);
        chk("rst_bubble",      32'(bubble_sel),   32'd0);
        chk("rst_flush",       32'(if_id_flush),  32'd0);
        chk("rst_fwd_a",       32'(fwd_a),        32'd0);
        chk("rst_fwd_b",       32'(fwd_b),        32'd0);
        chk("rst_stall_cnt",   32'(stall_cycles), 32'd0);
        chk("rst_state",       32'(state_dbg),    32'(RUN));

        clear_inputs();
        reset = 1'b1;
        #1;
        chk("idle_pc_write",    32'(pc_write),    32'd1);
        chk("idle_if_id_write", 32'(if_id_write), 32'd1);
        chk("idle_bubble",      32'(bubble_sel),  32'd0);

        // Forwarding priority and register-0 guard.
        rs_ex = 5'd3; rw_mem = 5'd3; reg_write_mem = 1'b1;
        rw_wb = 5'd3; reg_write_wb = 1'b1; rt_ex = 5'd5;
        #1;
        chk("fwd_a_mem_wins", 32'(fwd_a), 32'b10);
        chk("fwd_b_nomatch",  32'(fwd_b), 32'b00);
        reg_write_mem = 1'b0;
        #1;
        chk("fwd_a_wb", 32'(fwd_a), 32'b01);
        rs_ex = 5'd0;
        #1;
        chk("fwd_a_rf", 32'(fwd_a), 32'b00);
        rt_ex = 5'd0; rw_mem = 5'd0; rw_wb = 5'd0;
        reg_write_mem = 1'b1; reg_write_wb = 1'b1;
        #1;
        chk("fwd_b_r0_guard", 32'(fwd_b), 32'b00);
        rt_ex = 5'd9; rw_mem = 5'd9; rw_wb = 5'd9;
        #1;
        chk("fwd_b_mem", 32'(fwd_b), 32'b10);
        rw_mem = 5'd4;
        #1;
        chk("fwd_b_wb", 32'(fwd_b), 32'b01);
        clear_inputs();

        // Load-use against ex_rw=0 is never a hazard; against rs_id it is.
        ex_mem_read = 1'b1; ex_rw = 5'd0; rs_id = 5'd0;
        #1;
        chk("lu_r0_no_stall", 32'(pc_write), 32'd1);
        ex_rw = 5'd2; rs_id = 5'd2;
        #1;
        chk("lu_rs_bubble", 32'(bubble_sel), 32'd1);
        clear_inputs();
        #1;

        // Load-use, MEM_STALL=3: exactly three stall cycles. Branch, mc_start
        // and mc_done raised in the middle of the stall are all ignored.
        @(negedge clock);
        ex_mem_read = 1'b1; ex_rw = 5'd7; rt_id = 5'd7;
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i == 1);
            mc_start     = (i == 1);
            mc_done      = (i == 1);
            #1;
            chk($sformatf("lu_pc_write_%0d", i),    32'(pc_write),    32'd0);
            chk($sformatf("lu_if_id_write_%0d", i), 32'(if_id_write), 32'd0);
            chk($sformatf("lu_bubble_%0d", i),      32'(bubble_sel),  32'd1);
            chk($sformatf("lu_flush_%0d", i),       32'(if_id_flush), 32'd0);
            if (i > 0) chk($sformatf("lu_state_%0d", i), 32'(state_dbg), 32'(LOAD_STALL));
            @(negedge clock);
        end
        clear_inputs();
        #1;
        chk("lu_done_pc_write", 32'(pc_write),       32'd1);
        chk("lu_done_state",    32'(state_dbg),      32'(RUN));
        chk("lu_done_cnt",      32'(stall_cycles),   32'd3);
        chk("lu_done_cnt_s",    32'(stall_cycles_s), 32'd3);

        // Same hazard with a taken branch: flush one cycle, no stall.
        ex_mem_read = 1'b1; ex_rw = 5'd7; rt_id = 5'd7; branch_taken = 1'b1;
        #1;
        chk("br_flush",     32'(if_id_flush), 32'd1);
        chk("br_pc_write",  32'(pc_write),    32'd1);
        chk("br_bubble",    32'(bubble_sel),  32'd0);
        @(negedge clock);
        clear_inputs();
        #1;
        chk("br_after_flush", 32'(if_id_flush),  32'd0);
        chk("br_after_state", 32'(state_dbg),    32'(RUN));
        chk("br_after_cnt",   32'(stall_cycles), 32'd3);

        // mc_done while in RUN is ignored.
        mc_done = 1'b1;
        #1;
        chk("mcd_run_pc_write", 32'(pc_write), 32'd1);
        @(negedge clock);
        mc_done = 1'b0;
        #1;
        chk("mcd_run_state", 32'(state_dbg), 32'(RUN));

        // Multi-cycle op: start, done five cycles later -> four stall cycles.
        mc_start = 1'b1;
        #1;
        chk("mc_start_no_stall", 32'(pc_write), 32'd1);
        @(negedge clock);
        mc_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("mc_pc_write_%0d", i), 32'(pc_write),  32'd0);
            chk($sformatf("mc_bubble_%0d", i),   32'(bubble_sel), 32'd1);
            chk($sformatf("mc_state_%0d", i),    32'(state_dbg), 32'(MC_WAIT));
            @(negedge clock);
        end
        mc_done = 1'b1;
        #1;
        chk("mc_release_pc_write", 32'(pc_write),    32'd1);
        chk("mc_release_if_id",    32'(if_id_write), 32'd1);
        chk("mc_release_bubble",   32'(bubble_sel),  32'd0);
        chk("mc_release_state",    32'(state_dbg),   32'(MC_WAIT));
        @(negedge clock);
        mc_done = 1'b0;
        #1;
        chk("mc_after_state", 32'(state_dbg),      32'(RUN));
        chk("mc_after_cnt",   32'(stall_cycles),   32'd7);
        chk("mc_after_cnt_s", 32'(stall_cycles_s), 32'd7);

        // Reset during MC_WAIT cycle 2.
        mc_start = 1'b1;
        #1;
        @(negedge clock);
        mc_start = 1'b0;
        #1;
        chk("rmc_cycle1_stall", 32'(pc_write), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rmc_in_rst_pc_write", 32'(pc_write),   32'd1);
        chk("rmc_in_rst_bubble",   32'(bubble_sel), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rmc_state",      32'(state_dbg),      32'(RUN));
        chk("rmc_pc_write",   32'(pc_write),       32'd1);
        chk("rmc_cnt",        32'(stall_cycles),   32'd0);
        chk("rmc_cnt_s",      32'(stall_cycles_s), 32'd0);

        // Twenty stall cycles: 16-bit counter reads 20, 4-bit saturates at 15.
        mc_start = 1'b1;
        #1;
        @(negedge clock);
        mc_start = 1'b0;
        repeat (20) @(negedge clock);
        #1;
        chk("sat_still_stalled", 32'(pc_write),       32'd0);
        chk("sat_cnt_wide",      32'(stall_cycles),   32'd20);
        chk("sat_cnt_narrow",    32'(stall_cycles_s), 32'd15);
        mc_done = 1'b1;
        @(negedge clock);
        mc_done = 1'b0;
        #1;
        chk("sat_end_state",    32'(state_dbg),      32'(RUN));
        chk("sat_end_cnt_hold", 32'(stall_cycles_s), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
